// File: rtl/master_out_port.sv
// Initiator-side serial bus transmitter: valid/ready handshake, then LSB-first
// streaming of address, per-beat write data and burst word on three lines.
module master_out_port #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int BEAT_CYC = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_burst_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              data_taken,
  output logic              busy,
  output logic              done,
  output logic              master_valid,
  input  logic              slave_ready,
  output logic              read_en,
  output logic              write_en,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst
);

  localparam int CYC_W = $clog2(BEAT_CYC);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BEAT_CYC - 1);
  localparam logic [CYC_W-1:0] PRE_LAST = CYC_W'(BEAT_CYC - 2);

  typedef enum logic [1:0] {IDLE, HANDSHAKE, XFER, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_sh;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] beat;
  logic [DATA_W-1:0] data_sh;
  logic [ADDR_W:0]   burst_sh;
  logic [CYC_W-1:0]  cyc;
  logic              is_write;
  logic              last_beat;

  assign last_beat = (beat == len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_sh      <= '0;
      len          <= '0;
      beat         <= '0;
      data_sh      <= '0;
      burst_sh     <= '0;
      cyc          <= '0;
      is_write     <= 1'b0;
      data_taken   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      master_valid <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      tx_address   <= 1'b0;
      tx_data      <= 1'b0;
      tx_burst     <= 1'b0;
    end else begin
      data_taken <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state        <= HANDSHAKE;
            busy         <= 1'b1;
            master_valid <= 1'b1;
            read_en      <= !req_write;
            write_en     <= req_write;
            is_write     <= req_write;
            len          <= req_burst_len;
            beat         <= '0;
            cyc          <= '0;
            // Shifters hold the bits still to be sent; bit 0 goes straight out.
            tx_address   <= req_addr[0];
            addr_sh      <= req_addr >> 1;
            if (req_write) begin
              tx_data    <= wr_data[0];
              data_sh    <= wr_data >> 1;
              data_taken <= 1'b1;
            end else begin
              tx_data    <= 1'b0;
              data_sh    <= '0;
            end
            if (req_burst_len != '0) begin
              tx_burst <= 1'b1;
              burst_sh <= {1'b0, req_burst_len};
            end else begin
              tx_burst <= 1'b0;
              burst_sh <= '0;
            end
          end
        end
        HANDSHAKE: begin
          if (slave_ready) begin
            state        <= XFER;
            master_valid <= 1'b0;
            cyc          <= CYC_W'(1);
            tx_address   <= addr_sh[0];
            addr_sh      <= addr_sh >> 1;
            tx_data      <= data_sh[0];
            data_sh      <= data_sh >> 1;
            tx_burst     <= burst_sh[0];
            burst_sh     <= burst_sh >> 1;
          end
        end
        XFER: begin
          if (cyc == LAST_CYC && last_beat) begin
            state      <= DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            read_en    <= 1'b0;
            write_en   <= 1'b0;
            tx_address <= 1'b0;
            tx_data    <= 1'b0;
            tx_burst   <= 1'b0;
          end else begin
            tx_address <= addr_sh[0];
            addr_sh    <= addr_sh >> 1;
            tx_burst   <= burst_sh[0];
            burst_sh   <= burst_sh >> 1;
            if (cyc == LAST_CYC) begin
              cyc     <= '0;
              beat    <= beat + ADDR_W'(1);
              tx_data <= is_write & wr_data[0];
              data_sh <= is_write ? (wr_data >> 1) : '0;
            end else begin
              cyc     <= cyc + CYC_W'(1);
              tx_data <= data_sh[0];
              data_sh <= data_sh >> 1;
              // Pulse spans the last cycle of a beat, whose closing edge captures wr_data.
              data_taken <= is_write && (cyc == PRE_LAST) && !last_beat;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_out_port.sv
// Randomized self-checking bench for master_out_port with a per-cycle
// reference model of the serial line behaviour.
module tb_master_out_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_write;
  logic [11:0] req_addr;
  logic [11:0] req_burst_len;
  logic [7:0]  wr_data;
  logic        data_taken, busy, done, master_valid, slave_ready;
  logic        read_en, write_en, tx_address, tx_data, tx_burst;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  words [0:31];
  logic [8:0]  obs;

  always #5 clk = ~clk;

  // {data_taken, busy, done, master_valid, read_en, write_en, tx_address, tx_data, tx_burst}
  assign obs = {data_taken, busy, done, master_valid, read_en, write_en,
                tx_address, tx_data, tx_burst};

  master_out_port #(.ADDR_W(12), .DATA_W(8), .BEAT_CYC(12)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_burst_len(req_burst_len), .wr_data(wr_data),
    .data_taken(data_taken), .busy(busy), .done(done),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .read_en(read_en), .write_en(write_en), .tx_address(tx_address),
    .tx_data(tx_data), .tx_burst(tx_burst)
  );

  // Runs one transaction from an IDLE cycle; entry and exit just after a rising edge.
  task automatic do_txn(input logic [11:0] addr, input logic [11:0] len,
                        input logic wr, input int unsigned wait_cyc,
                        input logic noisy, input string tag);
    int unsigned total, bword, beat_i, pos;
    logic        edt, ea, ed, eb;
    logic [8:0]  exp;
    total = 12 * (32'(len) + 1);
    bword = (len != 0) ? (32'(len) * 2 + 1) : 0;
    req = 1'b1; req_write = wr; req_addr = addr; req_burst_len = len;
    wr_data = words[0];
    slave_ready = 1'($urandom);
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL %s idle: got %b expected %b", tag, obs, 9'b0);
    end
    @(posedge clk); #1;
    req = noisy; req_write = 1'($urandom); req_addr = 12'($urandom);
    req_burst_len = 12'($urandom);
    wr_data = (len != 0) ? words[1] : 8'($urandom);
    for (int unsigned k = 0; k < wait_cyc; k++) begin
      slave_ready = 1'b0;
      @(negedge clk);
      exp = {wr && (k == 0), 1'b1, 1'b0, 1'b1, !wr, wr, addr[0],
             wr & words[0][0], (bword & 1) != 0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s wait k=%0d: got %b expected %b", tag, k, obs, exp);
      end
      @(posedge clk); #1;
      if (noisy) begin
        req_write = 1'($urandom); req_addr = 12'($urandom); req_burst_len = 12'($urandom);
      end
    end
    slave_ready = 1'b1;
    for (int unsigned c = 0; c <= total; c++) begin
      beat_i = c / 12;
      pos    = c % 12;
      @(negedge clk);
      if (c < total) begin
        edt = wr && ((c == 0 && wait_cyc == 0) || (pos == 11 && beat_i < 32'(len)));
        ea  = ((addr >> c) & 12'd1) != 0;
        ed  = wr && (pos < 8) && (((words[beat_i] >> pos) & 8'd1) != 0);
        eb  = (c <= 12) && (((bword >> c) & 1) != 0);
        exp = {edt, 1'b1, 1'b0, (c == 0), !wr, wr, ea, ed, eb};
      end else begin
        exp = 9'b001000000;
      end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle=%0d: got %b expected %b", tag, c, obs, exp);
      end
      @(posedge clk); #1;
      slave_ready = 1'($urandom);
      if (pos == 11 && beat_i < 32'(len))
        wr_data = (beat_i + 2 <= 32'(len)) ? words[beat_i + 2] : 8'($urandom);
      if (noisy) begin
        req_write = 1'($urandom); req_addr = 12'($urandom); req_burst_len = 12'($urandom);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b1; req_write = 1'b1; req_addr = 12'hFFF;
    req_burst_len = 12'h003; wr_data = 8'hFF; slave_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 9'b0);
    end
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_write_single();
    words[0] = 8'h3B;
    do_txn(12'hA5C, 12'd0, 1'b1, 0, 1'b0, "wr_single");
  endtask

  task automatic test_read_wait();
    do_txn(12'h001, 12'd0, 1'b0, 5, 1'b0, "rd_wait");
  endtask

  task automatic test_burst();
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    do_txn(12'($urandom), 12'd2, 1'b1, 0, 1'b0, "wr_burst3");
  endtask

  task automatic test_reset_midway();
    req = 1'b1; req_write = 1'b1; req_addr = 12'($urandom);
    req_burst_len = 12'($urandom_range(0, 3)); wr_data = 8'($urandom);
    slave_ready = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midway_busy: got %b expected 1", busy);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", obs, 9'b0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs, 9'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
    do_txn(12'($urandom), 12'd3, 1'b1, 1, 1'b0, "after_reset");
  endtask

  task automatic test_ignore_req();
    for (int i = 0; i < 3; i++) words[i] = 8'($urandom);
    do_txn(12'($urandom), 12'd1, 1'b1, 2, 1'b1, "noisy_req");
    for (int i = 0; i < 3; i++) words[i] = 8'($urandom);
    do_txn(12'($urandom), 12'd2, 1'b1, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_random();
    logic [11:0] len;
    for (int t = 0; t < 12; t++) begin
      len = (t == 11) ? 12'd30 : 12'($urandom_range(0, 6));
      for (int i = 0; i < 32; i++) words[i] = 8'($urandom);
      do_txn(12'($urandom), len, 1'($urandom), $urandom_range(0, 3), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_wait();
    test_burst();
    test_reset_midway();
    test_ignore_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
